// File: rtl/mem_subsystem_if.sv
// rtl/mem_subsystem_if.sv - processor-side request/acknowledge bus into the memory subsystem
// The master drives a request and holds it until ack. The slave returns ack, busy, read data and addr_err.
interface mem_subsystem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              ack;
    logic              busy;
    logic              addr_err;

    modport master (
        output req, we, addr, din,
        input  dout, ack, busy, addr_err
    );

    modport slave (
        input  req, we, addr, din,
        output dout, ack, busy, addr_err
    );
endinterface

// File: rtl/mem_subsystem.sv
// rtl/mem_subsystem.sv - RAM plus two memory-mapped I/O registers behind a req/ack port with programmable wait states
// Each request runs IDLE -> WAIT -> ACCESS -> DONE. Decode and commit happen at the ACCESS closing edge.
module mem_subsystem #(
    parameter int                 DATA_W      = 16,
    parameter int                 ADDR_W      = 16,
    parameter int                 RAM_AW      = 12,
    parameter int                 WAIT_STATES = 1,
    parameter logic [ADDR_W-1:0]  IO_OUT_ADDR = {ADDR_W{1'b1}},
    parameter logic [ADDR_W-1:0]  IO_IN_ADDR  = {{(ADDR_W-1){1'b1}}, 1'b0}
) (
    input  logic              clk,
    input  logic              reset,
    mem_subsystem_if.slave    bus,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_strobe
);

    localparam logic [ADDR_W:0] RAM_DEPTH = {{ADDR_W{1'b0}}, 1'b1} << RAM_AW;
    localparam logic [3:0]      CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    if (RAM_AW < 1 || RAM_AW > ADDR_W) begin : g_bad_ram_aw
        $error("mem_subsystem: RAM_AW must be in 1..ADDR_W");
    end
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
        $error("mem_subsystem: WAIT_STATES must be in 0..15");
    end
    if ({1'b0, IO_OUT_ADDR} < RAM_DEPTH || {1'b0, IO_IN_ADDR} < RAM_DEPTH) begin : g_bad_io_overlap
        $error("mem_subsystem: I/O addresses must lie above the RAM range");
    end
    if (IO_OUT_ADDR == IO_IN_ADDR) begin : g_bad_io_same
        $error("mem_subsystem: IO_OUT_ADDR and IO_IN_ADDR must differ");
    end

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              ram_we;

    logic [DATA_W-1:0] mem [2**RAM_AW];

    logic in_ram, is_out, is_in, unmapped;
    assign in_ram   = {1'b0, addr_q} < RAM_DEPTH;
    assign is_out   = addr_q == IO_OUT_ADDR;
    assign is_in    = addr_q == IO_IN_ADDR;
    assign unmapped = !in_ram && !is_out && !is_in;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        din_d    = din_q;
        dout_d   = dout_q;
        io_out_d = io_out_q;
        ram_we   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    din_d   = bus.din;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                state_d = S_DONE;
                // Writes to IO_IN_ADDR or unmapped space fall through and are dropped.
                if (we_q) begin
                    if (is_out) begin
                        io_out_d = din_q;
                    end else if (in_ram) begin
                        ram_we = 1'b1;
                    end
                end else if (is_out) begin
                    dout_d = io_out_q;
                end else if (is_in) begin
                    dout_d = io_in;
                end else if (in_ram) begin
                    dout_d = mem[addr_q[RAM_AW-1:0]];
                end else begin
                    dout_d = '0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            dout_q   <= '0;
            io_out_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            io_out_q <= io_out_d;
        end
    end

    // RAM is never cleared; reset only blocks a commit that lands on the same edge.
    always_ff @(posedge clk) begin
        if (ram_we && !reset) begin
            mem[addr_q[RAM_AW-1:0]] <= din_q;
        end
    end

    assign bus.ack       = state_q == S_DONE;
    assign bus.busy      = state_q != S_IDLE;
    assign bus.addr_err  = (state_q == S_DONE) && unmapped;
    assign bus.dout      = dout_q;
    assign io_out        = io_out_q;
    assign io_out_strobe = (state_q == S_DONE) && we_q && is_out;

endmodule
